// File: rtl/async_fifo_core_pkg.sv
// Shared constants and helpers for async_fifo_core.
`timescale 1ns/1ps
package async_fifo_core_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefDepth = 2;

  // Ceiling log2, usable in constant expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/async_fifo_core_mem.sv
// DEPTH x WIDTH register array: one write port, one registered read port.
`timescale 1ns/1ps
module async_fifo_core_mem
  import async_fifo_core_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage has no reset; contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register: loads only on an accepted read, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/async_fifo_core.sv
// Single-clock FIFO with full/empty flags and registered read data.
// Optional sticky overflow/underflow outputs: define ASYNC_FIFO_CORE_ERR_FLAGS_EN.
`timescale 1ns/1ps
module async_fifo_core
  import async_fifo_core_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW = clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_push,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
  output logic             o_overflow,
  output logic             o_underflow,
`endif
  output logic [WIDTH-1:0] o_rdata
);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        push_ok, pop_ok;

  // Flags and request qualification from the registered pointers.
  always_comb begin
    o_empty = (wptr_q == rptr_q);
    o_full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    push_ok = i_push && !o_full;
    pop_ok  = i_pop && !o_empty;
  end

  // Next pointers wrap naturally modulo 2^(AW+1).
  always_comb begin
    wptr_d = wptr_q + {{AW{1'b0}}, push_ok};
    rptr_d = rptr_q + {{AW{1'b0}}, pop_ok};
  end

  // Pointer registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  async_fifo_core_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (i_clk),
    .rst   (i_rst),
    .we    (push_ok),
    .waddr (wptr_q[AW-1:0]),
    .wdata (i_wdata),
    .re    (pop_ok),
    .raddr (rptr_q[AW-1:0]),
    .rdata (o_rdata)
  );

`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (i_push && o_full) overflow_q <= 1'b1;
      if (i_pop && o_empty) underflow_q <= 1'b1;
    end
  end

  assign o_overflow  = overflow_q;
  assign o_underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo_core.sv
// Randomised and directed bench for async_fifo_core with a queue-based model.
`timescale 1ns/1ps
module tb_async_fifo_core;

  localparam int unsigned W = 16;
  localparam int unsigned D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         push = 1'b0;
  logic         pop = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         full, empty;
  logic [W-1:0] rdata;
`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
  logic         overflow, underflow;
`endif

  int total = 0;
  int bad = 0;

  // Reference model: stored words, expected read words, sticky errors.
  logic [W-1:0] mdl_q[$];
  logic [W-1:0] exp_q[$];
  bit           mdl_ovf = 1'b0;
  bit           mdl_udf = 1'b0;
  logic [W-1:0] held = '0;

  async_fifo_core #(
    .WIDTH (W),
    .DEPTH (D)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wdata     (wdata),
    .i_push      (push),
    .i_pop       (pop),
    .o_full      (full),
    .o_empty     (empty),
`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
    .o_overflow  (overflow),
    .o_underflow (underflow),
`endif
    .o_rdata     (rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle; model advances at the edge from its pre-edge state.
  task automatic step(input bit p, input bit q, input logic [W-1:0] d);
    bit m_full, m_empty;
    push  = p;
    pop   = q;
    wdata = d;
    @(posedge clk);
    m_full  = (mdl_q.size() == D);
    m_empty = (mdl_q.size() == 0);
    if (q && !m_empty) exp_q.push_back(mdl_q.pop_front());
    if (p && !m_full) mdl_q.push_back(d);
    if (p && m_full) mdl_ovf = 1'b1;
    if (q && m_empty) mdl_udf = 1'b1;
    #1;
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge.
  task automatic do_reset();
    push = 1'b0;
    pop  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_rdata", rdata, 0);
    mdl_q.delete();
    exp_q.delete();
    mdl_ovf = 1'b0;
    mdl_udf = 1'b0;
    #19;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Monitor: note accepted pops at the edge, compare on the falling edge.
  initial begin
    bit acc;
    forever begin
      @(posedge clk);
      acc = !rst && pop && !empty;
      @(negedge clk);
      if (rst) begin
        held = '0;
      end else begin
        if (acc) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: unexpected pop got %0h want none", rdata);
          end else begin
            held = exp_q.pop_front();
          end
        end
        check("mon_rdata", rdata, held);
        check("mon_empty", empty, mdl_q.size() == 0);
        check("mon_full", full, mdl_q.size() == D);
`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
        check("mon_overflow", overflow, mdl_ovf);
        check("mon_underflow", underflow, mdl_udf);
`endif
      end
    end
  end

  initial begin
    #3;
    check("init_empty", empty, 1);
    check("init_full", full, 0);
    check("init_rdata", rdata, 0);
    #9;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill and drain.
    step(1, 0, 16'h0005);
    check("fill1_empty", empty, 0);
    check("fill1_full", full, 0);
    step(1, 0, 16'h0011);
    check("fill2_full", full, 1);
    step(0, 1, 16'h0000);
    check("drain1_rdata", rdata, 16'h0005);
    step(0, 1, 16'h0000);
    check("drain2_rdata", rdata, 16'h0011);
    check("drain2_empty", empty, 1);

    // Overflow: pushes while full are dropped.
    step(1, 0, 16'h0021);
    step(1, 0, 16'h0022);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 16'($urandom));
      check("ovf_full", full, 1);
    end
`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
    check("ovf_flag", overflow, 1);
`endif
    step(0, 1, 16'h0000);
    check("ovf_pop1", rdata, 16'h0021);
    step(0, 1, 16'h0000);
    check("ovf_pop2", rdata, 16'h0022);

    // Underflow: pops on empty leave data and pointers alone.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 16'h0000);
      check("udf_rdata", rdata, 16'h0022);
      check("udf_empty", empty, 1);
    end
`ifdef ASYNC_FIFO_CORE_ERR_FLAGS_EN
    check("udf_flag", underflow, 1);
`endif
    step(1, 0, 16'h0033);
    step(0, 1, 16'h0000);
    check("udf_after", rdata, 16'h0033);
    check("udf_after_empty", empty, 1);

    // Simultaneous push and pop with one entry stored; no bypass on empty.
    step(1, 0, 16'h0044);
    step(1, 1, 16'h0007);
    check("sim_rdata", rdata, 16'h0044);
    check("sim_empty", empty, 0);
    check("sim_full", full, 0);
    step(0, 1, 16'h0000);
    check("sim_next", rdata, 16'h0007);
    step(1, 1, 16'h0099);
    check("sim_empty_nobypass", rdata, 16'h0007);
    step(0, 1, 16'h0000);
    check("sim_empty_push", rdata, 16'h0099);

    // Wrap: interleaved rounds through several pointer wraps.
    for (int i = 1; i <= 10; i++) begin
      step(1, 0, 16'(i));
      step(0, 1, 16'h0000);
      check("wrap_rdata", rdata, 32'(i));
    end

    // Reset in the middle of operation with one entry stored.
    step(1, 0, 16'h0055);
    step(1, 0, 16'h0066);
    step(0, 1, 16'h0000);
    check("pre_rst_rdata", rdata, 16'h0055);
    do_reset();
    check("post_rst_empty", empty, 1);
    check("post_rst_rdata", rdata, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end
    step(0, 0, 16'h0000);
    step(0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
